sevenseg_scan_driver: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 24 ++
 rtl/sevenseg_hex_font.sv | 11 +
 rtl/sevenseg_scan_driver.sv | 162 ++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment bit indices, hex font table and lookup.
// Font entries are active-high {g..a}. Drivers invert them for common-anode pins.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam seg_t FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return FONT[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_hex_font.sv
// Combinational hex nibble to active-high segment pattern {g..a}.
module sevenseg_hex_font
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered frame.
// Optional macro SEVENSEG_DIM_EN adds a BRIGHT input that PWM-gates the anodes.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  CLK100MHZ,
  input  logic                  RESETN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [4*DIGITS-1:0]   IN_DATA,
  input  logic [DIGITS-1:0]     IN_DP,
  input  logic [DIGITS-1:0]     IN_BLANK,
`ifdef SEVENSEG_DIM_EN
  input  logic [3:0]            BRIGHT,
`endif
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic                  FRAME
);

  localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned S_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0] PC_BLANK = PC_W'(BLANK_CYCLES);
  localparam logic [S_W-1:0]  S_LAST   = S_W'(DIGITS - 1);

  // Scan counters
  logic [PC_W-1:0] pc_q, pc_d;
  logic [S_W-1:0]  s_q, s_d;
  logic            pc_wrap, frame_end;

  always_comb begin
    pc_wrap   = (pc_q == PC_LAST);
    frame_end = pc_wrap && (s_q == S_LAST);
    pc_d      = pc_wrap ? '0 : pc_q + 1'b1;
    s_d       = s_q;
    if (pc_wrap) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      pc_q <= '0;
      s_q  <= '0;
    end else begin
      pc_q <= pc_d;
      s_q  <= s_d;
    end
  end

  // Frame buffers
  logic [4*DIGITS-1:0] pend_data_q, disp_data_q;
  logic [DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [DIGITS-1:0]   pend_blank_q, disp_blank_q;
  logic                pend_full_q, pend_full_d;
  logic                accept, swap;

  assign IN_READY = !pend_full_q;
  assign accept   = IN_VALID && !pend_full_q;
  // Only a frame already pending before the boundary cycle is promoted.
  assign swap     = frame_end && pend_full_q;

  always_comb begin
    pend_full_d = pend_full_q;
    if (swap) begin
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      pend_full_q  <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
    end else begin
      pend_full_q <= pend_full_d;
      if (accept) begin
        pend_data_q  <= IN_DATA;
        pend_dp_q    <= IN_DP;
        pend_blank_q <= IN_BLANK;
      end
      if (swap) begin
        disp_data_q  <= pend_data_q;
        disp_dp_q    <= pend_dp_q;
        disp_blank_q <= pend_blank_q;
      end
    end
  end

  // Slot decode
  logic [3:0]        cur_nibble;
  logic [6:0]        cur_seg;
  logic [DIGITS-1:0] slot_onehot;
  logic              lit;
  logic              an_on;

  assign cur_nibble = disp_data_q[{s_q, 2'b00} +: 4];

  sevenseg_hex_font u_font (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef SEVENSEG_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end

  assign an_on = lit && (pwm_q <= BRIGHT);
`else
  assign an_on = lit;
`endif

  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dp_d, frame_d;

  always_comb begin
    slot_onehot      = '0;
    slot_onehot[s_q] = 1'b1;
    lit              = (pc_q >= PC_BLANK) && !disp_blank_q[s_q];
    an_d             = an_on ? ~slot_onehot : '1;
    seg_d            = lit ? ~cur_seg : '1;
    dp_d             = lit ? ~disp_dp_q[s_q] : 1'b1;
    frame_d          = (pc_q == '0) && (s_q == '0);
  end

  // Outputs lag the counters by one cycle.
  always_ff @(posedge CLK100MHZ or negedge RESETN) begin
    if (!RESETN) begin
      AN    <= '1;
      SEG   <= '1;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else begin
      AN    <= an_d;
      SEG   <= seg_d;
      DP    <= dp_d;
      FRAME <= frame_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomized bench for sevenseg_scan_driver against a cycle-count based reference model.
module tb_sevenseg_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 8;
  localparam int unsigned BLANKC   = 2;
  localparam int unsigned FRAMELEN = DIGITS * PRESCALE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic [3:0]  in_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;
`ifdef SEVENSEG_DIM_EN
  logic [3:0]  bright = 4'd3;
`endif

  sevenseg_scan_driver #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANKC)
  ) dut (
    .CLK100MHZ (clk),
    .RESETN    (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .IN_DP     (in_dp),
    .IN_BLANK  (in_blank),
`ifdef SEVENSEG_DIM_EN
    .BRIGHT    (bright),
`endif
    .AN        (an),
    .SEG       (seg),
    .DP        (dp),
    .FRAME     (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference state: t counts active clock edges since reset release.
  int unsigned t;
  logic [15:0] m_disp_data, m_pend_data;
  logic [3:0]  m_disp_dp, m_pend_dp, m_disp_blank, m_pend_blank;
  bit          m_pend_full;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_frame;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, got, want);
    end
  endtask

  task automatic model_reset();
    t            = 0;
    m_pend_full  = 1'b0;
    m_disp_data  = '0;
    m_disp_dp    = '0;
    m_disp_blank = '1;
    m_pend_data  = '0;
    m_pend_dp    = '0;
    m_pend_blank = '0;
    exp_an       = 4'hF;
    exp_seg      = 7'h7F;
    exp_dp       = 1'b1;
    exp_frame    = 1'b0;
  endtask

  task automatic check_outputs();
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame", 32'(frame), 32'(exp_frame));
    check("ready", 32'(in_ready), 32'(!m_pend_full));
  endtask

  // What the pins show after the edge that ends cycle t, then buffer bookkeeping.
  task automatic model_edge(input bit v, input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] b);
    int unsigned pc, slot;
    bit on;
    pc        = t % PRESCALE;
    slot      = (t / PRESCALE) % DIGITS;
    exp_frame = (t % FRAMELEN) == 0;
    on        = (pc >= BLANKC) && !m_disp_blank[slot];
    exp_an    = 4'hF;
    exp_seg   = 7'h7F;
    exp_dp    = 1'b1;
    if (on) begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = ~font[m_disp_data[slot*4 +: 4]];
      exp_dp  = ~m_disp_dp[slot];
`ifdef SEVENSEG_DIM_EN
      if ((t % 16) > bright) exp_an = 4'hF;
`endif
    end
    if ((t % FRAMELEN) == FRAMELEN - 1 && m_pend_full) begin
      m_disp_data  = m_pend_data;
      m_disp_dp    = m_pend_dp;
      m_disp_blank = m_pend_blank;
      m_pend_full  = 1'b0;
    end else if (v && !m_pend_full) begin
      m_pend_data  = d;
      m_pend_dp    = p;
      m_pend_blank = b;
      m_pend_full  = 1'b1;
    end
    t++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input logic [15:0] d, input logic [3:0] p,
                       input logic [3:0] b);
    check_outputs();
    in_valid = v;
    in_data  = d;
    in_dp    = p;
    in_blank = b;
    @(posedge clk);
    model_edge(v, d, p, b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Holds the frame offered until accepted, bounded.
  task automatic send(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4 * FRAMELEN && !done; i++) begin
      done = !m_pend_full;
      cycle(1'b1, d, p, b);
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic apply_reset(input int n);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dp    = '0;
    in_blank = '0;
    model_reset();
    @(negedge clk);
    apply_reset(2);

    // Blank display after reset; FRAME every 32 cycles
    idle(70);

    send(16'h1234, 4'b0010, 4'b0000);
    idle(80);

    // Back-to-back frames exercise backpressure
    send(16'h5678, 4'b0001, 4'b0000);
    send(16'h9ABC, 4'b1000, 4'b0000);
    idle(2 * FRAMELEN + 8);

    // Offer exactly on the swap cycle with pending empty
    found = 1'b0;
    for (int i = 0; i < 4 * FRAMELEN && !found; i++) begin
      if ((t % FRAMELEN) == FRAMELEN - 1 && !m_pend_full) found = 1'b1;
      else idle(1);
    end
    if (!found) check("swap_wait_timeout", 32'd0, 32'd1);
    cycle(1'b1, 16'hABCD, 4'b0000, 4'b0000);
    idle(2 * FRAMELEN + 4);

    send(16'hF00D, 4'b0000, 4'b1000);
    idle(2 * FRAMELEN + 4);

    for (int i = 0; i < 1200; i++) begin
      logic [3:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cycle($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom), rb);
    end

    // Mid-frame reset with a pending frame waiting
    idle(FRAMELEN / 2 + 3);
    while (m_pend_full && t < 100000) idle(1);
    send(16'h4321, 4'b1111, 4'b0000);
    apply_reset(2);
    idle(3 * FRAMELEN);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
